// File: rtl/regfile_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_pkg : shared types/constants for the regfile writeback arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
package regfile_pkg;

  localparam logic [4:0] REG_ZERO = 5'd31;
  localparam int         NUM_REGS = 32;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_fifo : small writeback request FIFO with per-entry valid exposed
// Revision 1.0
// ----------------------------------------------------------------------------
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_req_t               push_req,
  input  logic                  pop,
  output wb_req_t               head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [DEPTH-1:0][4:0] entry_rd
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] valid_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = &valid;
  assign empty   = ~|valid;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Slots are tracked individually so occupancy and per-entry valid come from one source.
  always_comb begin
    valid_nxt = valid;
    if (pop_ok)  valid_nxt[rd_ptr] = 1'b0;
    if (push_ok) valid_nxt[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      valid  <= '0;
    end else begin
      valid <= valid_nxt;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_req;
  end

  assign head        = mem[rd_ptr];
  assign entry_valid = valid;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry_rd
      assign entry_rd[i] = mem[i].rd;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_wb_arbiter : shares the regfile write port between ALU and load results
// Revision 1.0
// ----------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [4:0]        ld_reg,
  input  logic [DATA_W-1:0] ld_data,
  output logic [4:0]        WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic [30:0]       pending,
  output logic              idle
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic                  alive;
  logic                  alu_push, ld_push;
  logic                  alu_full, alu_empty, ld_full, ld_empty;
  wb_req_t               alu_req, ld_req, alu_head, ld_head, grant_req;
  logic [DEPTH-1:0]      alu_ev, ld_ev;
  logic [DEPTH-1:0][4:0] alu_erd, ld_erd;
  logic                  grant_alu, grant_ld;
  logic [CNT_W-1:0]      starve_cnt;
  logic [NUM_REGS-1:0]   pend;

  // Readiness is held low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  assign alu_ready = alive & ~alu_full;
  assign ld_ready  = alive & ~ld_full;

  // Zero-register writes complete the handshake but are dropped here.
  assign alu_push = alu_valid & alu_ready & (alu_reg != REG_ZERO);
  assign ld_push  = ld_valid  & ld_ready  & (ld_reg  != REG_ZERO);

  assign alu_req = '{rd: alu_reg, data: 64'(alu_data)};
  assign ld_req  = '{rd: ld_reg,  data: 64'(ld_data)};

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (alu_push),
    .push_req    (alu_req),
    .pop         (grant_alu),
    .head        (alu_head),
    .full        (alu_full),
    .empty       (alu_empty),
    .entry_valid (alu_ev),
    .entry_rd    (alu_erd)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_ld_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (ld_push),
    .push_req    (ld_req),
    .pop         (grant_ld),
    .head        (ld_head),
    .full        (ld_full),
    .empty       (ld_empty),
    .entry_valid (ld_ev),
    .entry_rd    (ld_erd)
  );

  always_comb begin
    grant_alu = ~alu_empty & (ld_empty | (starve_cnt == LIMIT));
    grant_ld  = ~ld_empty & ~grant_alu;
    grant_req = grant_alu ? alu_head : ld_head;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (alu_empty || grant_alu) begin
      starve_cnt <= '0;
    end else if (grant_ld && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      RegWrite <= grant_alu | grant_ld;
      if (grant_alu || grant_ld) begin
        WriteRegister <= grant_req.rd;
        WriteData     <= DATA_W'(grant_req.data);
      end
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_ev[i]) pend[alu_erd[i]] = 1'b1;
      if (ld_ev[i])  pend[ld_erd[i]]  = 1'b1;
    end
    if (RegWrite) pend[WriteRegister] = 1'b1;
  end

  assign pending = pend[30:0];
  assign idle    = alu_empty & ld_empty & ~RegWrite;

endmodule
`default_nettype wire
